ps2_tx: RTL and testbench
=========================

Name: ps2_tx

Overview:
PS/2 host-to-device transmitter. It sends one command byte to the keyboard over the shared PS2_CLK/PS2_DAT open-drain lines, for example 0xED (set LEDs), 0xFF (reset) or 0xF3 (typematic). It sits beside the kb receiver on clock_25, is driven by an io-port write strobe, and reports acknowledge status back to the CPU through io.

Parameters:
INHIBIT_CYCLES, 3000, clock-low inhibit time in clocks (120 us at 25 MHz; must be at least 100 us).
REQ_CYCLES, 25, clocks with both clock and data held low before the clock is released.
TIMEOUT_CYCLES, 375000, limit in clocks from clock release to bus-idle (15 ms).

Ports:
clock  in  1  system clock (25 MHz); all logic on the rising edge.
reset  in  1  synchronous, active-high reset.
start  in  1  one-cycle request to send data; ignored while busy=1.
data  in  8  command byte, captured on the cycle start is accepted.
busy  out  1  high from the cycle after start is accepted until done.
done  out  1  one-cycle pulse when the transfer ends (success or failure).
err  out  2  status valid from done until the next start: 00 ok, 01 no ACK, 10 timeout.
ps_clk_i  in  1  raw PS2_CLK pin level.
ps_dat_i  in  1  raw PS2_DAT pin level.
ps_clk_oe  out  1  1 = drive PS2_CLK low; 0 = release (pulled high).
ps_dat_oe  out  1  1 = drive PS2_DAT low; 0 = release.

Behaviour:
- Reset: state IDLE; busy=0, done=0, err=00, ps_clk_oe=0, ps_dat_oe=0; counters cleared. Reset mid-transfer releases both lines on the next edge and aborts with no done pulse.
- Input conditioning: ps_clk_i and ps_dat_i each pass through a 2-FF synchroniser. A falling edge (fall) is registered when the synchronised clock is 1 in the previous cycle and 0 in the current one.
- Frame: a 10-bit shift of {stop=1, parity, data[7:0]}, sent LSB first after the start bit. parity = ~^data (odd parity). ps_dat_oe = ~current bit.
- IDLE: outputs released. When start=1, capture data, clear err, set busy=1, ps_clk_oe=1 on the next cycle, and go to INHIBIT.
- INHIBIT: ps_clk_oe=1, ps_dat_oe=0 for INHIBIT_CYCLES clocks, then go to REQ.
- REQ: ps_clk_oe=1, ps_dat_oe=1 (start bit) for REQ_CYCLES clocks. Then set ps_clk_oe=0, clear the timeout counter and the bit index, and go to SHIFT.
- SHIFT: ps_dat_oe holds the start bit (1) until the first fall. On fall number k (k=1..10), ps_dat_oe = ~frame[k-1] from the next cycle. Bit index 9 is the stop bit, so ps_dat_oe=0. The fall after the stop bit is output goes to ACK.
- ACK: on the same cycle as that 11th fall, sample the synchronised data line. 0 means acknowledged; 1 sets err=01. Then go to WAIT_IDLE.
- WAIT_IDLE: lines released. When both the synchronised clock and data are 1, pulse done=1 and set busy=0 on the same cycle, then go to IDLE.
- Timeout: the counter runs in SHIFT, ACK and WAIT_IDLE. On reaching TIMEOUT_CYCLES: release both lines, set err=10, pulse done, go to IDLE. Timeout overrides err=01.
- Simultaneous events: start together with done is ignored, because busy is still 1 that cycle. A start accepted in IDLE is the only way to begin a transfer.
- The block never drives a line high. The top level wires each pin as oe ? 0 : Z.
- Suggested encoding: 3-bit state, 19-bit counter shared between the phase timers and the timeout, 4-bit bit index.

Test Plan:
- Send 0xED with a device model that clocks at ~12.5 kHz and ACKs. Required: clock held low for 3000 cycles, then data low; bits seen on device rising edges are 0, 1,0,1,1,0,1,1,1, parity=1, stop=1. done pulses once with err=00, busy goes 1 to 0, and both oe=0 afterwards.
- Send 0x01 and then 0x00 back-to-back. Required: parity bit is 0 for 0x01 and 1 for 0x00. The second start, issued one cycle after done, is accepted and begins INHIBIT.
- Device model does not ACK (data stays high on the 11th clock). Required: err=01, a single done pulse, lines released.
- Device model never clocks after the clock is released. Required: done at exactly TIMEOUT_CYCLES cycles after the release, err=10, ps_dat_oe=0.
- start pulsed while busy during SHIFT with data=0xFF. Required: ignored; the byte on the wire is still the original one.
- reset asserted during bit 4 of SHIFT. Required: next cycle ps_clk_oe=0, ps_dat_oe=0, busy=0, no done pulse; a subsequent send of 0xF4 completes with err=00.

Source files
------------

// File: rtl/ps2_tx.sv
// ----------------------------------------------------------------------------
// ps2_tx : PS/2 host-to-device command transmitter
//
// Sends one command byte (e.g. 0xED set-LEDs, 0xFF reset, 0xF3 typematic) to
// a PS/2 device over the shared open-drain PS2_CLK / PS2_DAT lines.
// The block only ever pulls a line low; the pad is wired as oe ? 1'b0 : 1'bz.
//
// Sequence: inhibit (clock low) -> request-to-send (clock and data low) ->
// release clock and shift out start, 8 data bits (LSB first), odd parity and
// stop, one bit per device-generated falling clock edge -> sample the device
// ACK on the 11th falling edge -> wait for the bus to go idle.
//
// Ports
//   clock      in   system clock (25 MHz), rising edge
//   reset      in   synchronous active-high reset
//   start      in   one-cycle send request, ignored while busy
//   data[7:0]  in   command byte, captured when start is accepted
//   busy       out  transfer in progress
//   done       out  one-cycle pulse at the end of a transfer
//   err[1:0]   out  00 ok, 01 no ACK, 10 timeout (valid from done to next start)
//   ps_clk_i   in   raw PS2_CLK pin level
//   ps_dat_i   in   raw PS2_DAT pin level
//   ps_clk_oe  out  1 = pull PS2_CLK low
//   ps_dat_oe  out  1 = pull PS2_DAT low
// ----------------------------------------------------------------------------
module ps2_tx #(
    parameter int INHIBIT_CYCLES = 3000,
    parameter int REQ_CYCLES     = 25,
    parameter int TIMEOUT_CYCLES = 375000
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       start,
    input  logic [7:0] data,
    output logic       busy,
    output logic       done,
    output logic [1:0] err,
    input  logic       ps_clk_i,
    input  logic       ps_dat_i,
    output logic       ps_clk_oe,
    output logic       ps_dat_oe
);

    localparam logic [2:0] ST_IDLE      = 3'd0;
    localparam logic [2:0] ST_INHIBIT   = 3'd1;
    localparam logic [2:0] ST_REQ       = 3'd2;
    localparam logic [2:0] ST_SHIFT     = 3'd3;
    localparam logic [2:0] ST_ACK       = 3'd4;
    localparam logic [2:0] ST_WAIT_IDLE = 3'd5;

    localparam logic [1:0] ERR_OK      = 2'b00;
    localparam logic [1:0] ERR_NOACK   = 2'b01;
    localparam logic [1:0] ERR_TIMEOUT = 2'b10;

    // Terminal counts: a phase lasting N cycles ends when the counter,
    // which starts at 0, reaches N-1.
    localparam logic [18:0] INHIBIT_LAST = 19'(INHIBIT_CYCLES - 1);
    localparam logic [18:0] REQ_LAST     = 19'(REQ_CYCLES - 1);
    localparam logic [18:0] TIMEOUT_LAST = 19'(TIMEOUT_CYCLES - 1);

    // Index of the stop bit in the frame shift register.
    localparam logic [3:0] STOP_IDX = 4'd9;

    // ------------------------------------------------------------------
    // Pin synchronisers: bit 0 = clock line, bit 1 = data line.
    // Reset to 1 because an idle PS/2 bus floats high.
    // ------------------------------------------------------------------
    logic [1:0] pin_raw;
    logic [1:0] pin_sync;

    assign pin_raw = {ps_dat_i, ps_clk_i};

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_sync
            logic meta_reg;
            logic sync_reg;

            always_ff @(posedge clock) begin
                if (reset) begin
                    meta_reg <= 1'b1;
                    sync_reg <= 1'b1;
                end else begin
                    meta_reg <= pin_raw[gi];
                    sync_reg <= meta_reg;
                end
            end

            assign pin_sync[gi] = sync_reg;
        end
    endgenerate

    logic clk_sync;
    logic dat_sync;
    logic clk_prev_reg;
    logic fall;

    assign clk_sync = pin_sync[0];
    assign dat_sync = pin_sync[1];
    assign fall     = clk_prev_reg & ~clk_sync;

    always_ff @(posedge clock) begin
        if (reset) begin
            clk_prev_reg <= 1'b1;
        end else begin
            clk_prev_reg <= clk_sync;
        end
    end

    // ------------------------------------------------------------------
    // Control state
    // ------------------------------------------------------------------
    logic [2:0]  state_reg,  state_next;
    logic [18:0] cnt_reg,    cnt_next;     // phase timer and timeout share this
    logic [3:0]  bit_reg,    bit_next;
    logic [9:0]  frame_reg,  frame_next;   // {stop, parity, data[7:0]}
    logic        busy_reg,   busy_next;
    logic        done_reg,   done_next;
    logic [1:0]  err_reg,    err_next;
    logic        clk_oe_reg, clk_oe_next;
    logic        dat_oe_reg, dat_oe_next;

    logic timeout_hit;
    assign timeout_hit = (cnt_reg == TIMEOUT_LAST);

    always_comb begin
        state_next  = state_reg;
        cnt_next    = cnt_reg;
        bit_next    = bit_reg;
        frame_next  = frame_reg;
        busy_next   = busy_reg;
        done_next   = 1'b0;
        err_next    = err_reg;
        clk_oe_next = clk_oe_reg;
        dat_oe_next = dat_oe_reg;

        case (state_reg)
            ST_IDLE: begin
                clk_oe_next = 1'b0;
                dat_oe_next = 1'b0;
                if (start) begin
                    // Odd parity: the parity bit makes the total count of ones odd.
                    frame_next  = {1'b1, ~^data, data};
                    err_next    = ERR_OK;
                    busy_next   = 1'b1;
                    clk_oe_next = 1'b1;
                    cnt_next    = '0;
                    state_next  = ST_INHIBIT;
                end
            end

            ST_INHIBIT: begin
                if (cnt_reg == INHIBIT_LAST) begin
                    cnt_next    = '0;
                    dat_oe_next = 1'b1;        // start bit, request-to-send
                    state_next  = ST_REQ;
                end else begin
                    cnt_next = cnt_reg + 19'd1;
                end
            end

            ST_REQ: begin
                if (cnt_reg == REQ_LAST) begin
                    clk_oe_next = 1'b0;        // hand the clock to the device
                    cnt_next    = '0;          // timeout window starts here
                    bit_next    = '0;
                    state_next  = ST_SHIFT;
                end else begin
                    cnt_next = cnt_reg + 19'd1;
                end
            end

            ST_SHIFT, ST_ACK, ST_WAIT_IDLE: begin
                if (timeout_hit) begin
                    // Timeout wins over any pending no-ACK status.
                    clk_oe_next = 1'b0;
                    dat_oe_next = 1'b0;
                    err_next    = ERR_TIMEOUT;
                    done_next   = 1'b1;
                    busy_next   = 1'b0;
                    cnt_next    = '0;
                    state_next  = ST_IDLE;
                end else begin
                    cnt_next = cnt_reg + 19'd1;
                    case (state_reg)
                        ST_SHIFT: begin
                            // The device reads on its rising edge, so the next
                            // bit goes out right after each falling edge.
                            if (fall) begin
                                dat_oe_next = ~frame_reg[bit_reg];
                                if (bit_reg == STOP_IDX) begin
                                    bit_next   = '0;
                                    state_next = ST_ACK;
                                end else begin
                                    bit_next = bit_reg + 4'd1;
                                end
                            end
                        end

                        ST_ACK: begin
                            dat_oe_next = 1'b0;
                            // The device pulls data low during the 11th clock.
                            if (fall) begin
                                err_next   = dat_sync ? ERR_NOACK : ERR_OK;
                                state_next = ST_WAIT_IDLE;
                            end
                        end

                        default: begin  // ST_WAIT_IDLE
                            clk_oe_next = 1'b0;
                            dat_oe_next = 1'b0;
                            if (clk_sync && dat_sync) begin
                                done_next  = 1'b1;
                                busy_next  = 1'b0;
                                cnt_next   = '0;
                                state_next = ST_IDLE;
                            end
                        end
                    endcase
                end
            end

            default: begin
                clk_oe_next = 1'b0;
                dat_oe_next = 1'b0;
                busy_next   = 1'b0;
                cnt_next    = '0;
                state_next  = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_reg  <= ST_IDLE;
            cnt_reg    <= '0;
            bit_reg    <= '0;
            frame_reg  <= '0;
            busy_reg   <= 1'b0;
            done_reg   <= 1'b0;
            err_reg    <= ERR_OK;
            clk_oe_reg <= 1'b0;
            dat_oe_reg <= 1'b0;
        end else begin
            state_reg  <= state_next;
            cnt_reg    <= cnt_next;
            bit_reg    <= bit_next;
            frame_reg  <= frame_next;
            busy_reg   <= busy_next;
            done_reg   <= done_next;
            err_reg    <= err_next;
            clk_oe_reg <= clk_oe_next;
            dat_oe_reg <= dat_oe_next;
        end
    end

    assign busy      = busy_reg;
    assign done      = done_reg;
    assign err       = err_reg;
    assign ps_clk_oe = clk_oe_reg;
    assign ps_dat_oe = dat_oe_reg;

endmodule

// File: tb/tb_ps2_tx.sv
// ----------------------------------------------------------------------------
// tb_ps2_tx : directed testbench for ps2_tx with a simple PS/2 device model.
// The device generates clocks with HALF-cycle low/high phases, records the
// data line on every rising clock edge and optionally ACKs on clock 11.
// ----------------------------------------------------------------------------
module tb_ps2_tx;

    localparam int INH  = 3000;
    localparam int REQ  = 25;
    localparam int TO   = 2000;
    localparam int HALF = 20;

    logic       clock = 1'b0;
    logic       reset;
    logic       start;
    logic [7:0] data_in;
    logic       busy;
    logic       done;
    logic [1:0] err;
    logic       ps_clk_oe;
    logic       ps_dat_oe;
    logic       dev_clk_low = 1'b0;
    logic       dev_dat_low = 1'b0;
    logic       clk_line;
    logic       dat_line;

    assign clk_line = ~(ps_clk_oe | dev_clk_low);
    assign dat_line = ~(ps_dat_oe | dev_dat_low);

    ps2_tx #(
        .INHIBIT_CYCLES(INH),
        .REQ_CYCLES    (REQ),
        .TIMEOUT_CYCLES(TO)
    ) dut (
        .clock    (clock),
        .reset    (reset),
        .start    (start),
        .data     (data_in),
        .busy     (busy),
        .done     (done),
        .err      (err),
        .ps_clk_i (clk_line),
        .ps_dat_i (dat_line),
        .ps_clk_oe(ps_clk_oe),
        .ps_dat_oe(ps_dat_oe)
    );

    always #20 clock = ~clock;

    int          n_total = 0;
    int          n_bad   = 0;

    int          since_rel;
    int          done_cnt;
    int          done_cyc;
    logic [1:0]  err_at_done;
    logic        dat_oe_at_done;
    int          inh_cnt;
    int          req_cnt;
    logic        acc_ok;
    logic [10:0] seen;
    logic        rst_clk_oe;
    logic        rst_dat_oe;
    logic        rst_busy;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end else begin
            $display("ok   %s: %0h", tag, got);
        end
    endtask

    // One clock: sample #1 after the edge and watch for done pulses.
    task automatic tick();
        @(posedge clock);
        #1;
        since_rel++;
        if (done) begin
            done_cnt++;
            if (done_cnt == 1) begin
                done_cyc       = since_rel;
                err_at_done    = err;
                dat_oe_at_done = ps_dat_oe;
            end
        end
    endtask

    // Issue start for byte b and play the device side of the transfer.
    // nclk: device clocks to generate (0 = device silent).
    // abort_k: assert reset during clock abort_k low phase (0 = never).
    // poke_k: pulse start with 0xFF during clock poke_k (0 = never).
    task automatic run_frame(input logic [7:0] b, input int nclk, input bit do_ack,
                             input int abort_k, input int poke_k);
        int guard;
        data_in  = b;
        start    = 1'b1;
        done_cnt = 0;
        done_cyc = -1;
        err_at_done    = 2'bxx;
        dat_oe_at_done = 1'bx;
        seen     = '0;
        inh_cnt  = 0;
        req_cnt  = 0;
        tick();
        start  = 1'b0;
        acc_ok = busy && ps_clk_oe;
        guard  = 0;
        while (ps_clk_oe && guard < 10000) begin
            if (ps_dat_oe) req_cnt++;
            else           inh_cnt++;
            tick();
            guard++;
        end
        check("clk_released", ps_clk_oe, 1'b0);
        since_rel = 0;
        seen[0]   = dat_line;   // start bit, seen as the clock line rises
        for (int k = 1; k <= nclk; k++) begin
            if (k == 11 && do_ack) dev_dat_low = 1'b1;
            repeat (4) tick();
            dev_clk_low = 1'b1;
            if (k == poke_k) begin
                data_in = 8'hFF;
                start   = 1'b1;
                tick();
                start   = 1'b0;
                data_in = b;
            end
            repeat (HALF) tick();
            if (k == abort_k) begin
                reset = 1'b1;
                tick();
                rst_clk_oe = ps_clk_oe;
                rst_dat_oe = ps_dat_oe;
                rst_busy   = busy;
                reset       = 1'b0;
                dev_clk_low = 1'b0;
                dev_dat_low = 1'b0;
                return;
            end
            dev_clk_low = 1'b0;
            if (k <= 10) seen[k] = dat_line;
            repeat (HALF) tick();
        end
        dev_dat_low = 1'b0;
        for (int i = 0; i < TO + 200 && done_cnt == 0; i++) tick();
    endtask

    initial begin
        reset   = 1'b1;
        start   = 1'b0;
        data_in = 8'h00;
        since_rel = 0;
        done_cnt  = 0;
        repeat (3) @(posedge clock);
        #1;
        reset = 1'b0;
        tick();
        check("rst_busy",   busy,      1'b0);
        check("rst_done",   done,      1'b0);
        check("rst_err",    err,       2'b00);
        check("rst_clk_oe", ps_clk_oe, 1'b0);
        check("rst_dat_oe", ps_dat_oe, 1'b0);

        // 0xED with ACK: start 0, data 1,0,1,1,0,1,1,1, parity 1, stop 1
        run_frame(8'hED, 11, 1'b1, 0, 0);
        check("ed_accept",  acc_ok,   1'b1);
        check("ed_inhibit", inh_cnt,  INH);
        check("ed_req",     req_cnt,  REQ);
        check("ed_bits",    seen,     11'b1_1_11101101_0);
        check("ed_err",     err_at_done, 2'b00);
        repeat (20) tick();
        check("ed_done_cnt", done_cnt, 1);
        check("ed_busy",    busy,      1'b0);
        check("ed_clk_oe",  ps_clk_oe, 1'b0);
        check("ed_dat_oe",  ps_dat_oe, 1'b0);

        // 0x01 then 0x00 back-to-back; second start one cycle after done
        run_frame(8'h01, 11, 1'b1, 0, 0);
        check("b01_bits", seen, 11'b1_0_00000001_0);
        check("b01_done", done_cnt, 1);
        check("b01_err",  err_at_done, 2'b00);
        run_frame(8'h00, 11, 1'b1, 0, 0);
        check("b00_accept",  acc_ok,  1'b1);
        check("b00_inhibit", inh_cnt, INH);
        check("b00_bits",    seen,    11'b1_1_00000000_0);
        check("b00_err",     err_at_done, 2'b00);

        // No ACK from the device
        run_frame(8'hA5, 11, 1'b0, 0, 0);
        repeat (20) tick();
        check("nack_err",      err_at_done, 2'b01);
        check("nack_done_cnt", done_cnt,    1);
        check("nack_err_hold", err,         2'b01);
        check("nack_clk_oe",   ps_clk_oe,   1'b0);
        check("nack_dat_oe",   ps_dat_oe,   1'b0);

        // Silent device: timeout exactly TO cycles after clock release
        run_frame(8'hF3, 0, 1'b0, 0, 0);
        check("to_cycle",  done_cyc,       TO);
        check("to_err",    err_at_done,    2'b10);
        check("to_dat_oe", dat_oe_at_done, 1'b0);
        check("to_busy",   busy,           1'b0);

        // start with 0xFF while shifting is ignored
        run_frame(8'h3C, 11, 1'b1, 0, 3);
        check("poke_bits", seen, 11'b1_1_00111100_0);
        check("poke_done", done_cnt, 1);
        check("poke_err",  err_at_done, 2'b00);

        // Reset during the data bits aborts with no done pulse
        run_frame(8'hED, 11, 1'b1, 5, 0);
        check("abort_clk_oe", rst_clk_oe, 1'b0);
        check("abort_dat_oe", rst_dat_oe, 1'b0);
        check("abort_busy",   rst_busy,   1'b0);
        done_cnt = 0;
        repeat (100) tick();
        check("abort_no_done", done_cnt, 0);

        // Recovery send of 0xF4
        run_frame(8'hF4, 11, 1'b1, 0, 0);
        check("f4_bits", seen, 11'b1_0_11110100_0);
        check("f4_done", done_cnt, 1);
        check("f4_err",  err_at_done, 2'b00);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
